// File: rtl/vrf_wb_arbiter.sv
// Round-robin write-back arbiter for one lane's VRF write port.
// Grants one requester per cycle into a single-entry output register
// (valid/ready toward the VRF) and keeps per-source saturating stall counters.
module vrf_wb_arbiter #(
  parameter int NrReq = 2,
  parameter int DataW = 64,
  parameter int AddrW = 8,
  parameter int IdW   = 2,
  parameter int CntW  = 16,
  localparam int SrcW  = (NrReq > 1) ? $clog2(NrReq) : 1,
  localparam int StrbW = DataW / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NrReq-1:0]         req_valid_i,
  output logic [NrReq-1:0]         req_gnt_o,
  input  logic [NrReq*DataW-1:0]   req_wdata_i,
  input  logic [NrReq*StrbW-1:0]   req_wstrb_i,
  input  logic [NrReq*AddrW-1:0]   req_addr_i,
  input  logic [NrReq*IdW-1:0]     req_id_i,
  output logic                     wr_valid_o,
  input  logic                     wr_ready_i,
  output logic [DataW-1:0]         wr_wdata_o,
  output logic [StrbW-1:0]         wr_wstrb_o,
  output logic [AddrW-1:0]         wr_addr_o,
  output logic [IdW-1:0]           wr_id_o,
  output logic [SrcW-1:0]          wr_src_o,
  output logic [NrReq*CntW-1:0]    stall_cnt_o,
  input  logic                     stall_clr_i
);

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] cnt);
    return (&cnt) ? cnt : cnt + CntW'(1);
  endfunction

  // Round-robin pointer: first index examined by the next scan.
  logic [SrcW-1:0]  ptr;

  // Stage p0: combinational arbitration and field selection.
  logic             can_load_p0;
  logic             gnt_found_p0;
  logic [SrcW-1:0]  gnt_idx_p0;
  logic [NrReq-1:0] gnt_p0;
  logic [DataW-1:0] sel_wdata_p0;
  logic [StrbW-1:0] sel_wstrb_p0;
  logic [AddrW-1:0] sel_addr_p0;
  logic [IdW-1:0]   sel_id_p0;
  int               scan_k;

  // Stage p1: output register toward the VRF.
  logic             vld_p1;
  logic [DataW-1:0] wr_wdata_p1;
  logic [StrbW-1:0] wr_wstrb_p1;
  logic [AddrW-1:0] wr_addr_p1;
  logic [IdW-1:0]   wr_id_p1;
  logic [SrcW-1:0]  wr_src_p1;

  logic [NrReq-1:0][CntW-1:0] stall_cnt;

  // Scan requesters starting at ptr; the first valid one wins when the OR can load.
  always_comb begin
    gnt_p0       = '0;
    gnt_found_p0 = 1'b0;
    gnt_idx_p0   = '0;
    sel_wdata_p0 = '0;
    sel_wstrb_p0 = '0;
    sel_addr_p0  = '0;
    sel_id_p0    = '0;
    scan_k       = 0;
    can_load_p0  = !vld_p1 || wr_ready_i;
    if (can_load_p0 && !rst_i) begin
      for (int off = 0; off < NrReq; off++) begin
        scan_k = (int'(ptr) + off) % NrReq;
        if (!gnt_found_p0 && req_valid_i[scan_k]) begin
          gnt_found_p0       = 1'b1;
          gnt_idx_p0         = SrcW'(scan_k);
          gnt_p0[scan_k]     = 1'b1;
          sel_wdata_p0       = req_wdata_i[scan_k*DataW +: DataW];
          sel_wstrb_p0       = req_wstrb_i[scan_k*StrbW +: StrbW];
          sel_addr_p0        = req_addr_i[scan_k*AddrW +: AddrW];
          sel_id_p0          = req_id_i[scan_k*IdW +: IdW];
        end
      end
    end
  end

  // Load the OR on a grant (retiring any old entry in the same edge), else drain on ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1      <= 1'b0;
      ptr         <= '0;
      wr_wdata_p1 <= '0;
      wr_wstrb_p1 <= '0;
      wr_addr_p1  <= '0;
      wr_id_p1    <= '0;
      wr_src_p1   <= '0;
    end else if (gnt_found_p0) begin
      vld_p1      <= 1'b1;
      ptr         <= SrcW'((int'(gnt_idx_p0) + 1) % NrReq);
      wr_wdata_p1 <= sel_wdata_p0;
      wr_wstrb_p1 <= sel_wstrb_p0;
      wr_addr_p1  <= sel_addr_p0;
      wr_id_p1    <= sel_id_p0;
      wr_src_p1   <= gnt_idx_p0;
    end else if (wr_ready_i) begin
      vld_p1      <= 1'b0;
    end
  end

  // Count cycles each source waits with a valid request; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else begin
      for (int k = 0; k < NrReq; k++) begin
        if (stall_clr_i) begin
          stall_cnt[k] <= '0;
        end else if (req_valid_i[k] && !gnt_p0[k]) begin
          stall_cnt[k] <= sat_inc(stall_cnt[k]);
        end
      end
    end
  end

  assign req_gnt_o   = gnt_p0;
  assign wr_valid_o  = vld_p1;
  assign wr_wdata_o  = wr_wdata_p1;
  assign wr_wstrb_o  = wr_wstrb_p1;
  assign wr_addr_o   = wr_addr_p1;
  assign wr_id_o     = wr_id_p1;
  assign wr_src_o    = wr_src_p1;
  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Self-checking bench for vrf_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_vrf_wb_arbiter;

  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int AW   = 8;
  localparam int IW   = 2;
  localparam int CW   = 4;
  localparam int SRCW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    gnt;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N*AW-1:0] req_addr;
  logic [N*IW-1:0] req_id;
  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   wr_wdata;
  logic [SW-1:0]   wr_wstrb;
  logic [AW-1:0]   wr_addr;
  logic [IW-1:0]   wr_id;
  logic [SRCW-1:0] wr_src;
  logic [N*CW-1:0] stall_cnt;
  logic            clr;

  vrf_wb_arbiter #(.NrReq(N), .DataW(DW), .AddrW(AW), .IdW(IW), .CntW(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_gnt_o(gnt),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .req_addr_i(req_addr), .req_id_i(req_id),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .wr_wdata_o(wr_wdata), .wr_wstrb_o(wr_wstrb),
    .wr_addr_o(wr_addr), .wr_id_o(wr_id), .wr_src_o(wr_src),
    .stall_cnt_o(stall_cnt), .stall_clr_i(clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Source-side state: each source holds its fields until granted.
  logic          s_v[N];
  logic [DW-1:0] s_d[N];
  logic [SW-1:0] s_s[N];
  logic [AW-1:0] s_a[N];
  logic [IW-1:0] s_i[N];
  logic [N-1:0]  refill;

  // Reference model of what the VRF port should show.
  logic          m_v;
  int            m_ptr;
  logic [DW-1:0] m_d;
  logic [SW-1:0] m_s;
  logic [AW-1:0] m_a;
  logic [IW-1:0] m_i;
  int            m_src;
  int            m_cnt[N];

  logic [N-1:0]  obs_gnt;

  task automatic new_fields(input int k);
    s_v[k] = 1'b1;
    s_d[k] = $urandom;
    s_s[k] = SW'($urandom_range(0, (1 << SW) - 1));
    s_a[k] = AW'($urandom_range(0, (1 << AW) - 1));
    s_i[k] = IW'($urandom_range(0, (1 << IW) - 1));
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]            = s_v[k];
      req_wdata[k*DW +: DW]   = s_d[k];
      req_wstrb[k*SW +: SW]   = s_s[k];
      req_addr[k*AW +: AW]    = s_a[k];
      req_id[k*IW +: IW]      = s_i[k];
    end
  endtask

  // One clock: drive, check at the falling edge, advance model at the rising edge.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_gnt;
    drive();
    @(negedge clk);
    w = -1;
    if (!rst && (!m_v || wr_ready)) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (w < 0 && s_v[k]) w = k;
      end
    end
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    obs_gnt = gnt;
    check_eq("gnt", 64'(gnt), 64'(exp_gnt));
    check_eq("wr_valid", 64'(wr_valid), 64'(m_v));
    check_eq("wr_wdata", 64'(wr_wdata), 64'(m_d));
    check_eq("wr_wstrb", 64'(wr_wstrb), 64'(m_s));
    check_eq("wr_addr", 64'(wr_addr), 64'(m_a));
    check_eq("wr_id", 64'(wr_id), 64'(m_i));
    check_eq("wr_src", 64'(wr_src), 64'(m_src));
    for (int k = 0; k < N; k++)
      check_eq("stall_cnt", 64'(stall_cnt[k*CW +: CW]), 64'(m_cnt[k]));
    @(posedge clk);
    if (rst) begin
      m_v = 1'b0; m_ptr = 0; m_d = '0; m_s = '0; m_a = '0; m_i = '0; m_src = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (clr) m_cnt[k] = 0;
        else if (s_v[k] && w != k && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
      end
      if (w >= 0) begin
        m_v = 1'b1; m_d = s_d[w]; m_s = s_s[w]; m_a = s_a[w]; m_i = s_i[w];
        m_src = w; m_ptr = (w + 1) % N;
      end else if (wr_ready) begin
        m_v = 1'b0;
      end
    end
    if (w >= 0) begin
      if (refill[w]) new_fields(w);
      else s_v[w] = 1'b0;
    end
    #1;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int k);
    return stall_cnt[k*CW +: CW];
  endfunction

  initial begin
    int hi;
    rst = 1'b1; wr_ready = 1'b1; clr = 1'b0; refill = '0;
    m_v = 1'b0; m_ptr = 0; m_d = '0; m_s = '0; m_a = '0; m_i = '0; m_src = 0;
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0;
      new_fields(k);
    end
    drive();
    @(posedge clk); #1;

    // Reset held with every source requesting.
    repeat (2) begin
      cycle();
      check_eq("rst_gnt", 64'(obs_gnt), 64'(0));
      check_eq("rst_wr_valid", 64'(wr_valid), 64'(0));
    end
    rst = 1'b0;
    cycle();
    check_eq("first_gnt", 64'(obs_gnt), 64'(3'b001));
    cycle();
    cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;

    // Fairness between two continuously requesting sources.
    refill = 3'b011;
    new_fields(0); new_fields(1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("fair_gnt", 64'(obs_gnt), (i % 2 == 0) ? 64'(3'b001) : 64'(3'b010));
    end
    check_eq("fair_cnt0", 64'(cnt_of(0)), 64'(2));
    check_eq("fair_cnt1", 64'(cnt_of(1)), 64'(2));
    refill = '0;
    s_v[0] = 1'b0; s_v[1] = 1'b0;
    cycle();

    // Backpressure with a held OR entry.
    new_fields(1);
    s_a[1] = 8'h12; s_i[1] = 2'd3;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check_eq("bp_load_gnt", 64'(obs_gnt), 64'(3'b010));
    new_fields(0);
    wr_ready = 1'b0;
    repeat (5) begin
      cycle();
      check_eq("bp_no_gnt", 64'(obs_gnt), 64'(0));
    end
    check_eq("bp_cnt0", 64'(cnt_of(0)), 64'(5));
    check_eq("bp_addr", 64'(wr_addr), 64'(8'h12));
    check_eq("bp_id", 64'(wr_id), 64'(3));
    wr_ready = 1'b1;
    cycle();
    check_eq("bp_release_gnt", 64'(obs_gnt), 64'(3'b001));
    check_eq("bp_stay_valid", 64'(wr_valid), 64'(1));

    // Single source granted back to back.
    refill = 3'b010;
    new_fields(1);
    repeat (3) begin
      cycle();
      check_eq("single_gnt", 64'(obs_gnt), 64'(3'b010));
      check_eq("single_addr", 64'(wr_addr), 64'(m_a));
    end
    refill = '0;
    s_v[1] = 1'b0;

    // Saturation and clear priority.
    wr_ready = 1'b0;
    new_fields(0);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check_eq("clr_prio", 64'(cnt_of(0)), 64'(0));
    repeat (20) cycle();
    check_eq("sat_cnt", 64'(cnt_of(0)), 64'(CMAX));
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check_eq("clr_stall", 64'(cnt_of(0)), 64'(0));

    // Idle drain after a single write.
    wr_ready = 1'b1;
    cycle();
    check_eq("drain_gnt", 64'(obs_gnt), 64'(3'b001));
    hi = int'(wr_valid);
    repeat (3) begin
      cycle();
      hi += int'(wr_valid);
    end
    check_eq("drain_hi_cycles", 64'(hi), 64'(1));

    // Randomized traffic, including occasional mid-operation resets.
    for (int t = 0; t < 2000; t++) begin
      rst      = ($urandom_range(0, 199) == 0);
      wr_ready = ($urandom_range(0, 9) < 7);
      clr      = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < N; k++)
        if (!s_v[k] && $urandom_range(0, 1) == 1) new_fields(k);
      cycle();
    end
    rst = 1'b0; clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vrf_wb_arbiter.md
# vrf_wb_arbiter

Round-robin write-back arbiter for one lane's vector register file write port. It accepts write requests from all write-back sources in the lane (index 0 = vector load unit, index 1 = VALU, further indices reserved for future VFUs). It grants one request per cycle into a single-entry output register that drives the VRF write port under a valid/ready handshake. It also keeps per-source saturating stall counters for performance analysis.

## Interface
Parameters:
- `NrReq`, 2: number of write-back requesters; must be ≥ 1.
- `DataW`, 64: VRF data width in bits.
- `AddrW`, 8: VRF address width.
- `IdW`, 2: instruction-ID width.
- `CntW`, 16: stall-counter width.

Ports:
- `clk_i`  in  1  clock; all logic rising-edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NrReq  per-source write request valid.
- `req_gnt_o`  out  NrReq  per-source grant; one-hot or zero.
- `req_wdata_i`  in  NrReq×DataW  write data.
- `req_wstrb_i`  in  NrReq×(DataW/8)  byte strobes.
- `req_addr_i`  in  NrReq×AddrW  VRF address.
- `req_id_i`  in  NrReq×IdW  instruction ID.
- `wr_valid_o`  out  1  output register holds a write.
- `wr_ready_i`  in  1  VRF accepts the write this cycle.
- `wr_wdata_o`  out  DataW  registered write data.
- `wr_wstrb_o`  out  DataW/8  registered strobes.
- `wr_addr_o`  out  AddrW  registered address.
- `wr_id_o`  out  IdW  registered ID.
- `wr_src_o`  out  $clog2(NrReq) (min 1)  index of the source that owns the output entry.
- `stall_cnt_o`  out  NrReq×CntW  per-source stall-cycle counters.
- `stall_clr_i`  in  1  synchronous clear of all stall counters.

## Operation
- Output register (OR): one entry {wdata, wstrb, addr, id, src}, plus flag `wr_valid_o`.
- Load condition: `can_load = !wr_valid_o || wr_ready_i`. Back-to-back grants at full throughput are allowed.
- Arbitration, combinational:
  - When `can_load` is 1, pick the first asserted `req_valid_i[k]` scanning k = ptr, ptr+1, …, NrReq-1, 0, …, ptr-1 (modulo NrReq).
  - Assert `req_gnt_o[k]` for the winner only.
  - No grant when `can_load` is 0 or no request is valid.
- Grant semantics: a granted source's fields are captured into the OR at the next edge. The source must treat grant as consumption and must hold its fields stable while valid and not granted.
- Pointer `ptr`: on a grant to k, `ptr ← (k+1) mod NrReq`. Otherwise it holds. Reset value 0.
- `wr_valid_o` next state:
  - 1 on a grant.
  - Else 0 if `wr_ready_i`.
  - Else hold.
- OR fields update only on a grant. When `wr_valid_o` is 0 the fields are don't-care but must not be X after the first load.
- `req_gnt_o` never depends on `req_valid_i` of non-winning sources beyond the scan. The arbiter has no combinational path from `wr_ready_i` to `wr_valid_o`.
- Stall counter k:
  - Increments each cycle `req_valid_i[k] && !req_gnt_o[k]`.
  - Saturates at 2^CntW-1.
  - `stall_clr_i` sets all counters to 0 and has priority over increment.
- NrReq = 1: the pointer is a constant 0, and the block degenerates into a one-entry pipeline register with stall counting.

## Timing
- Reset (`rst_i` high at an edge):
  - `wr_valid_o`=0, `ptr`=0, `stall_cnt_o`=0.
  - `req_gnt_o`=0 while `rst_i` is high.
  - OR data fields cleared to 0.
- Reset mid-operation: an entry pending in the OR is dropped. Sources must also be reset.
- Latency: request valid in cycle t with `can_load` → gnt in t → `wr_valid_o` in t+1.
- Throughput: 1 write/cycle when `wr_ready_i` stays high.
- Full OR with `wr_ready_i`=0: no grants, all valid sources accumulate stall cycles.
- Simultaneous drain and load (`wr_valid_o`=1, `wr_ready_i`=1, request present): the old entry retires and the new one is loaded in the same edge, so `wr_valid_o` stays 1.
- Wrap-around: after a grant to NrReq-1, `ptr` becomes 0.

## Test plan
- Reset: hold `rst_i` 2 cycles with all requests valid → `req_gnt_o`=0 and `wr_valid_o`=0 during reset. The first cycle after reset grants source 0.
- Fairness: both sources valid continuously, `wr_ready_i`=1 → grants alternate 0,1,0,1. `wr_src_o` follows one cycle later. Both stall counters reach 2 after 4 cycles.
- Backpressure: load OR from source 1 with addr=0x12, id=3, then `wr_ready_i`=0 for 5 cycles with source 0 valid → OR holds addr 0x12 and id 3, no grants, `stall_cnt_o[0]`=5. On `wr_ready_i`=1, source 0 is granted the same cycle and `wr_valid_o` stays high.
- Single source: only source 1 valid for 3 cycles → 3 consecutive grants to 1, with data captured 1 cycle after each grant.
- Saturation/clear: CntW=4, source 0 starved 20 cycles → counter = 15. Assert `stall_clr_i` simultaneously with a stall → counter = 0.
- Idle drain: one write, then no requests, `wr_ready_i`=1 → `wr_valid_o` high exactly 1 cycle.
